// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional skid entry,
// flush-to-bubble, flushed-slot tag and saturating stall counter.
// Ports: clk, rst (async, active-high), flush,
//   in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data,
//   out_flushed (head came from a flush), stall_cnt (CNT_W bits).
module pipe_stage_reg #(
  parameter int unsigned      WIDTH   = 64,
  parameter int               SKID    = 1,
  parameter logic [WIDTH-1:0] BUBBLE  = '0,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_flushed,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             flushed_q;
  logic [CNT_W-1:0] stall_q;

  logic in_xfer;
  logic out_xfer;
  logic ld_main;
  logic ld_skid;
  logic mv_skid;
  logic drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    drain   = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = BUSY;
            ld_main = 1'b1;
          end
        end
        BUSY: begin
          unique case (1'b1)
            in_xfer && out_xfer: begin
              ld_main = 1'b1;
            end
            in_xfer && !out_xfer: begin
              // Only reachable with a skid entry: a
              // single-entry stage is not ready here.
              if (SKID != 0) begin
                state_d = FULL;
                ld_skid = 1'b1;
              end
            end
            out_xfer && !in_xfer: begin
              state_d = EMPTY;
              drain   = 1'b1;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (out_xfer) begin
            state_d = BUSY;
            mv_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // With a skid entry, in_ready depends only on state (plus the
  // flush gate) so it never sees a path from out_ready.
  always_comb begin
    out_valid = (state_q != EMPTY);
    if (SKID != 0) in_ready = (state_q != FULL);
    else           in_ready = !out_valid || out_ready;
    in_ready    = in_ready && !flush;
    in_xfer     = in_valid && in_ready;
    out_xfer    = out_valid && out_ready;
    out_data    = main_q;
    out_flushed = flushed_q;
    stall_cnt   = stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q    <= RST_VAL;
      skid_q    <= RST_VAL;
      flushed_q <= 1'b0;
    end else if (flush) begin
      main_q    <= BUBBLE;
      flushed_q <= 1'b1;
    end else begin
      if (ld_main)      main_q <= in_data;
      else if (mv_skid) main_q <= skid_q;
      else if (drain)   main_q <= BUBBLE;
      if (ld_skid) skid_q <= in_data;
      // The tag sticks until a real payload reaches the head.
      if (ld_main || mv_skid) flushed_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready) begin
      if (stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: three stage variants (skid, no skid, 4-bit counter)
// driven by directed and random traffic, checked against a queue model.
module tb_pipe_stage_reg;

  localparam int W = 16;
  localparam int N = 3;
  localparam logic [W-1:0] BUB = 16'hB0B0;
  localparam logic [W-1:0] RV  = 16'h5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic out_ready = 1'b0;

  logic         in_valid [N];
  logic [W-1:0] in_data  [N];
  logic         in_ready [N];
  logic         out_valid[N];
  logic [W-1:0] out_data [N];
  logic         out_flsh [N];
  logic [15:0]  cnt0;
  logic [15:0]  cnt1;
  logic [3:0]   cnt2;

  logic [W-1:0] q [N][$];
  bit  pushed[N];
  bit  acc   [N];
  bit  flg   [N];
  bit  ever  [N];
  int  cm    [N];
  int  seq   [N];
  int  lim;
  bit  rmode;
  int  n_chk  = 0;
  int  n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH(W), .SKID(1), .BUBBLE(BUB),
    .RST_VAL(RV), .CNT_W(16)
  ) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_data(out_data[0]),
    .out_flushed(out_flsh[0]), .stall_cnt(cnt0)
  );

  pipe_stage_reg #(
    .WIDTH(W), .SKID(0), .BUBBLE(BUB),
    .RST_VAL(RV), .CNT_W(16)
  ) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_data(out_data[1]),
    .out_flushed(out_flsh[1]), .stall_cnt(cnt1)
  );

  pipe_stage_reg #(
    .WIDTH(W), .SKID(1), .BUBBLE(BUB),
    .RST_VAL(RV), .CNT_W(4)
  ) u2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready), .out_data(out_data[2]),
    .out_flushed(out_flsh[2]), .stall_cnt(cnt2)
  );

  function automatic int cnt_of(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic int cmax(input int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  task automatic chk(input int i, input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL u%0d %s: got %0h expected %0h at %0t",
                  i, nm, got, exp, $time);
  endtask

  // One clock of upstream/downstream stimulus. Upstream holds a
  // payload until it is accepted, then moves to the next one.
  task automatic cycle(input bit ordy, input bit fl);
    @(posedge clk); #1;
    out_ready = ordy;
    flush = fl;
    for (int i = 0; i < N; i++) begin
      if (!in_valid[i] || acc[i]) begin
        if (rmode) begin
          in_valid[i] = ($urandom_range(9) < 7);
          in_data[i]  = W'($urandom);
        end else begin
          in_valid[i] = (seq[i] <= lim);
          in_data[i]  = W'(seq[i]);
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      acc[i] = !rst && in_valid[i] && in_ready[i];
      if (acc[i]) begin
        q[i].push_back(in_data[i]);
        pushed[i] = 1'b1;
        seq[i]++;
      end
    end
  endtask

  // Reset lands mid-cycle; outputs must react before any clock edge.
  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0;
      acc[i] = 1'b0;
      seq[i] = 1;
    end
    #1;
    for (int i = 0; i < N; i++) begin
      chk(i, "rst_out_valid", out_valid[i], 1'b0);
      chk(i, "rst_out_data", out_data[i], RV);
      chk(i, "rst_in_ready", in_ready[i], 1'b1);
      chk(i, "rst_flushed", out_flsh[i], 1'b0);
      chk(i, "rst_stall", cnt_of(i), 0);
    end
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  // Monitor: compares every cycle against the queue model, then
  // advances the model across the coming clock edge.
  always @(negedge clk) begin
    int occ;
    bit er;
    logic [W-1:0] ed;
    #1;
    for (int i = 0; i < N; i++) begin
      occ = q[i].size() - int'(pushed[i]);
      if (rst) begin
        q[i].delete();
        pushed[i] = 1'b0;
        flg[i] = 1'b0;
        ever[i] = 1'b0;
        cm[i] = 0;
      end else begin
        chk(i, "out_valid", out_valid[i], occ > 0);
        if (i != 1) er = !flush && (occ < 2);
        else        er = !flush && (occ == 0 || out_ready);
        chk(i, "in_ready", in_ready[i], er);
        if (occ > 0) ed = q[i][0];
        else         ed = ever[i] ? BUB : RV;
        chk(i, "out_data", out_data[i], ed);
        chk(i, "out_flushed", out_flsh[i], flg[i]);
        chk(i, "stall_cnt", cnt_of(i), cm[i]);
        if (occ > 0 && !out_ready && cm[i] < cmax(i)) cm[i]++;
        if (occ > 0 && out_ready) begin
          void'(q[i].pop_front());
          ever[i] = 1'b1;
        end
        if (flush) begin
          q[i].delete();
          flg[i] = 1'b1;
          ever[i] = 1'b1;
        end else if ((occ == 0 && pushed[i]) ||
                     (occ > 0 && out_ready && q[i].size() > 0)) begin
          flg[i] = 1'b0;
        end
        pushed[i] = 1'b0;
      end
    end
  end

  initial begin
    rmode = 1'b0;
    lim = 0;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0;
      in_data[i] = '0;
    end
    do_reset();

    // Full-rate stream 1..8.
    lim = 8;
    repeat (12) cycle(1'b1, 1'b0);
    for (int i = 0; i < N; i++) chk(i, "stream_stall", cnt_of(i), 0);

    // One-cycle out_ready drop with 2 at the head.
    do_reset();
    lim = 4;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    repeat (7) cycle(1'b1, 1'b0);
    for (int i = 0; i < N; i++) chk(i, "drop_stall", cnt_of(i), 1);

    // Flush while full with a third payload offered.
    do_reset();
    lim = 3;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (6) cycle(1'b1, 1'b0);

    // Counter saturation, unaffected by flush.
    do_reset();
    lim = 1;
    repeat (22) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    chk(0, "sat_wide", cnt_of(0), 21);
    chk(2, "sat_narrow", cnt_of(2), 15);
    cycle(1'b0, 1'b0);
    chk(0, "flush_keeps_cnt", cnt_of(0), 22);
    chk(2, "flush_keeps_sat", cnt_of(2), 15);

    // Asynchronous reset while full.
    do_reset();
    lim = 10;
    repeat (3) cycle(1'b0, 1'b0);
    chk(0, "pre_rst_full", in_ready[0], 1'b0);
    do_reset();
    repeat (4) cycle(1'b1, 1'b0);

    // Random traffic with occasional flush and reset.
    rmode = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(9) < 7, $urandom_range(19) == 0);
      if ($urandom_range(499) == 0) do_reset();
    end
    cycle(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque packed payload with a valid/ready handshake instead of a bare enable. It provides an optional two-entry skid buffer so `in_ready` is a registered signal, inserts a configurable bubble payload on flush or drain, and flags flushed slots downstream. It also keeps a saturating back-pressure counter for benchmarking.

## Interface
Parameters:
- `WIDTH`, default 64: payload width in bits, ≥1.
- `SKID`, default 1:
  - 1: two-entry skid buffer; `in_ready` is registered.
  - 0: single entry; `in_ready` is combinational from `out_ready`.
- `BUBBLE`, default 0: payload driven on `out_data` after a flush or drain. It is `WIDTH` bits wide; callers pass an encoded NOP bundle.
- `RST_VAL`, default 0: payload value held after reset.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `flush`, input, 1: synchronous flush; highest priority after `rst`.
- `in_valid`, input, 1: upstream payload valid.
- `in_ready`, output, 1: stage can accept a payload this cycle.
- `in_data`, input, `WIDTH`: upstream payload.
- `out_valid`, output, 1: `out_data` holds a live payload.
- `out_ready`, input, 1: downstream accepts `out_data` this cycle.
- `out_data`, output, `WIDTH`: head payload. Equals `BUBBLE` or `RST_VAL` when not valid.
- `out_flushed`, output, 1: the head slot was produced by a flush.
- `stall_cnt`, output, `CNT_W`: cycles with `out_valid && !out_ready`, saturating.

## Operation
- Transfer rules:
  - In transfer: `in_valid && in_ready`.
  - Out transfer: `out_valid && out_ready`.
- State machine, `SKID=1`, with two registers `main` and `skid`:
  - EMPTY: `in_ready=1`, `out_valid=0`. In transfer loads `main` and goes to BUSY.
  - BUSY: `in_ready=1`, `out_valid=1`.
    - In and out transfer together: `main` ← `in_data`; stay in BUSY.
    - In transfer only: `skid` ← `in_data`; go to FULL.
    - Out transfer only: `main` ← `BUBBLE`; go to EMPTY.
  - FULL: `in_ready=0`, `out_valid=1`. Out transfer: `main` ← `skid`; go to BUSY.
- `SKID=0`: states EMPTY and BUSY only; `in_ready = !out_valid || out_ready`. The transitions are the BUSY/EMPTY subset above.
- `in_ready` is forced to 0 whenever `flush=1`. No in transfer is ever accepted and then silently lost.
- Flush, when `flush=1` at the clock edge:
  - All entries are discarded and the state goes to EMPTY.
  - `main` ← `BUBBLE`; `out_flushed` ← 1.
  - Any concurrent out transfer still counts as consumed downstream.
- `out_flushed` clears on the first non-flush edge that loads `main` from `in_data` or `skid`. It holds while the stage stays EMPTY after the flush.
- `stall_cnt`:
  - Increments on each edge with `out_valid && !out_ready`.
  - Saturates at 2^`CNT_W`−1 with no wrap.
  - Cleared only by `rst`; flush does not clear it.
- Payload bits are never inspected or modified; width is exactly `WIDTH` on every path.

## Timing
- Reset values, asynchronous and immediate:
  - State EMPTY.
  - `out_valid=0`.
  - `out_data=RST_VAL`, and `skid=RST_VAL`.
  - `out_flushed=0`.
  - `stall_cnt=0`.
  - `in_ready=1`, or per the combinational rule when `SKID=0`.
- Latency: an in transfer at edge N gives `out_valid=1` and the new `out_data` after edge N.
- Throughput:
  - One payload per cycle at steady state in both modes.
  - With `SKID=1`, a single-cycle `out_ready` drop costs no upstream bubble.
- With `SKID=1`, `in_ready` is a pure function of the state register, with no path from `out_ready` (except the `flush` gate).
- Order is strictly FIFO: `main` before `skid`.
- Reset deasserted mid-stream: the first accepted payload after reset appears one cycle later, with no stale data.
- Flush and reset are never both needed; reset dominates.

## Test plan
- Reset, then stream `in_data` 1..8 with `in_valid=1` and `out_ready=1` -> `out_data` 1..8 on consecutive cycles one cycle later; `stall_cnt=0`.
- `SKID=1`: stream 1..4 and drop `out_ready` for one cycle when 2 is at the head -> state goes FULL with 3 in `skid`; `in_ready=0` for one cycle; output order is 1,2,3,4 with no loss or duplicate; `stall_cnt=1`.
- `SKID=0`, same stimulus -> `in_ready` falls in the same cycle as `out_ready`; order is 1,2,3,4; `stall_cnt=1`.
- Stage FULL (A in `main`, B in `skid`), assert `flush` for one cycle with `in_valid=1`, `in_data=C` -> `in_ready=0` that cycle; next cycle `out_valid=0`, `out_data=BUBBLE`, `out_flushed=1`. C is not consumed; presenting C again delivers it with `out_flushed=0`.
- `CNT_W=4`: hold `out_valid=1` with `out_ready=0` for 20 cycles -> `stall_cnt` saturates at 15; a later flush leaves it at 15; `rst` returns it to 0.
- Assert `rst` asynchronously mid-stream in the FULL state -> `out_valid=0`, `out_data=RST_VAL` and state EMPTY immediately, before the next clock edge.
